// File: rtl/bus_grant_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// bus_grant_scheduler_pkg
// Shared bus package: bus message codes, scheduler FSM state encodings and
// a ceil-log2 helper used to size index vectors.
// No ports (package).
// ---------------------------------------------------------------------------
package bus_grant_scheduler_pkg;

  // Bus message codes carried on the snoop bus once a cache owns it.
  typedef enum logic [2:0] {
    MSG_NOP       = 3'd0,
    MSG_READ      = 3'd1,
    MSG_READX     = 3'd2,
    MSG_UPGRADE   = 3'd3,
    MSG_WRITEBACK = 3'd4
  } bus_msg_e;

  // Scheduler FSM encodings (legacy-compatible constants).
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  // Ceil(log2(value)), never less than 1 so a vector is always declarable.
  function automatic int bus_log2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bus_grant_scheduler_if.sv
// ---------------------------------------------------------------------------
// bus_grant_scheduler_if
// Request/grant bundle between the L1 caches and the bus grant scheduler.
//   req         caches -> scheduler  per-cache request level
//   done        caches -> scheduler  per-cache end-of-transaction pulse
//   grant       scheduler -> caches  one-hot grant
//   grant_idx   scheduler -> caches  binary owner index
//   grant_valid scheduler -> caches  a cache owns the bus
//   timeout_err scheduler -> caches  forced-release pulse
// Modports: master (cache side), slave (scheduler side).
// ---------------------------------------------------------------------------
interface bus_grant_scheduler_if
  import bus_grant_scheduler_pkg::*;
#(
  parameter int NUM_CACHES = 4
) ();
  localparam int IDX_W = bus_log2(NUM_CACHES);

  logic [NUM_CACHES-1:0] req;
  logic [NUM_CACHES-1:0] done;
  logic [NUM_CACHES-1:0] grant;
  logic [IDX_W-1:0]      grant_idx;
  logic                  grant_valid;
  logic                  timeout_err;

  modport master (
    output req, done,
    input  grant, grant_idx, grant_valid, timeout_err
  );

  modport slave (
    input  req, done,
    output grant, grant_idx, grant_valid, timeout_err
  );
endinterface

// File: rtl/bus_grant_scheduler_rr_select.sv
// ---------------------------------------------------------------------------
// rr_select
// Combinational round-robin pick: first asserted req at or after rr_ptr,
// searching upward and wrapping NUM_CACHES-1 -> 0.
//   req     input   NUM_CACHES  request vector
//   rr_ptr  input   IDX_W       search start
//   idx     output  IDX_W       selected index (0 when none)
//   valid   output  1           some request found
// ---------------------------------------------------------------------------
module rr_select
  import bus_grant_scheduler_pkg::*;
#(
  parameter int NUM_CACHES = 4,
  parameter int IDX_W      = 2
) (
  input  logic [NUM_CACHES-1:0] req,
  input  logic [IDX_W-1:0]      rr_ptr,
  output logic [IDX_W-1:0]      idx,
  output logic                  valid
);
  int               cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    idx      = '0;
    valid    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 0; i < NUM_CACHES; i++) begin
      cand = int'(rr_ptr) + i;
      if (cand >= NUM_CACHES) cand = cand - NUM_CACHES;
      cand_idx = cand[IDX_W-1:0];
      if (!valid && req[cand_idx]) begin
        valid = 1'b1;
        idx   = cand_idx;
      end
    end
  end
endmodule

// File: rtl/one_hot_encoder.sv
// ---------------------------------------------------------------------------
// one_hot_encoder
// Binary index to one-hot vector; all zero when en is low.
//   idx      input   IDX_W  binary index
//   en       input   1      enable
//   one_hot  output  WIDTH  decoded vector
// ---------------------------------------------------------------------------
module one_hot_encoder #(
  parameter int WIDTH = 4,
  parameter int IDX_W = 2
) (
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [WIDTH-1:0] one_hot
);
  assign one_hot = en ? (WIDTH'(1) << idx) : '0;
endmodule

// File: rtl/bus_grant_scheduler.sv
// ---------------------------------------------------------------------------
// bus_grant_scheduler
// Round-robin bus arbiter for NUM_CACHES L1 caches with a one-cycle GAP
// between owners (two-cycle turnaround including the IDLE arbitration cycle).
//
//   state | meaning
//   IDLE  | no owner; arbitrate from rr_ptr
//   BUSY  | owner holds the bus until done, req drop or timeout
//   GAP   | one dead cycle after release, then IDLE
//
// Ports:
//   clock  input  rising-edge clock
//   reset  input  synchronous, active-high
//   bus    bus_grant_scheduler_if.slave (req, done in; grant, grant_idx,
//          grant_valid, timeout_err out)
// Build option: define BUS_TIMEOUT_EN to bound ownership at TIMEOUT_CYCLES
// BUSY cycles; otherwise ownership is unbounded and timeout_err is 0.
// ---------------------------------------------------------------------------
module bus_grant_scheduler
  import bus_grant_scheduler_pkg::*;
#(
  parameter int NUM_CACHES     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  bus_grant_scheduler_if.slave  bus
);
  localparam int IDX_W = bus_log2(NUM_CACHES);

  logic [1:0]       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] owner_idx;
  logic             owner_valid;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_valid;
  logic             owner_done;
  logic             owner_req;
  logic             timeout_hit;
  logic             release_bus;
  logic [IDX_W-1:0] next_ptr;

  rr_select #(
    .NUM_CACHES (NUM_CACHES),
    .IDX_W      (IDX_W)
  ) u_rr_select (
    .req    (bus.req),
    .rr_ptr (rr_ptr),
    .idx    (sel_idx),
    .valid  (sel_valid)
  );

  // owner_idx is held at 0 whenever owner_valid is low, so the decoded grant
  // and grant_idx are consistent by construction.
  one_hot_encoder #(
    .WIDTH (NUM_CACHES),
    .IDX_W (IDX_W)
  ) u_one_hot_encoder (
    .idx     (owner_idx),
    .en      (owner_valid),
    .one_hot (bus.grant)
  );

  assign owner_done  = bus.done[owner_idx];
  assign owner_req   = bus.req[owner_idx];
  assign release_bus = owner_done | ~owner_req | timeout_hit;
  assign next_ptr    = (owner_idx == IDX_W'(NUM_CACHES - 1)) ? '0
                                                            : owner_idx + IDX_W'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      owner_idx   <= '0;
      owner_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sel_valid) begin
            state       <= ST_BUSY;
            owner_idx   <= sel_idx;
            owner_valid <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (release_bus) begin
            state       <= ST_GAP;
            owner_idx   <= '0;
            owner_valid <= 1'b0;
            rr_ptr      <= next_ptr;
          end
        end
        ST_GAP: begin
          state <= ST_IDLE;
        end
        default: begin
          state       <= ST_IDLE;
          owner_idx   <= '0;
          owner_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant_idx   = owner_idx;
  assign bus.grant_valid = owner_valid;

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = bus_log2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] busy_cnt;
  logic             timeout_err_q;

  // Counter is 0 in the first BUSY cycle, so reaching TIMEOUT_CYCLES-1
  // means the owner has had exactly TIMEOUT_CYCLES cycles.
  assign timeout_hit = (state == ST_BUSY) && (busy_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_cnt      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      timeout_err_q <= 1'b0;
      if (state == ST_IDLE && sel_valid) begin
        busy_cnt <= '0;
      end else if (state == ST_BUSY && !release_bus) begin
        busy_cnt <= busy_cnt + CNT_W'(1);
      end
      // Only a release caused purely by the timeout is flagged; the pulse
      // lands in the GAP cycle.
      if (timeout_hit && owner_req && !owner_done) begin
        timeout_err_q <= 1'b1;
      end
    end
  end

  assign bus.timeout_err = timeout_err_q;
`else
  assign timeout_hit     = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_grant_scheduler.sv
// ---------------------------------------------------------------------------
// tb_bus_grant_scheduler
// Directed bench for bus_grant_scheduler. Stimulus pushes expected grants
// (index, idle gap before it, ownership length) and expected per-cycle
// output snapshots into queues; a monitor on the falling edge pops and
// compares. Define BUS_TIMEOUT_EN to exercise the forced-release path with
// TIMEOUT_CYCLES=8.
// ---------------------------------------------------------------------------
module tb_bus_grant_scheduler;
  import bus_grant_scheduler_pkg::*;

  localparam int N = 4;
`ifdef BUS_TIMEOUT_EN
  localparam int TO       = 8;
  localparam int EXP_TERR = 1;
`else
  localparam int TO       = 64;
  localparam int EXP_TERR = 0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  bus_grant_scheduler_if #(.NUM_CACHES(N)) bus ();

  bus_grant_scheduler #(
    .NUM_CACHES     (N),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // grant scoreboard: index, expected invalid cycles before it (-1 = any),
  // expected ownership length (-1 = any)
  int sb_idx[$];
  int sb_gap[$];
  int sb_len[$];

  // per-cycle snapshot expectations
  string      dq_name[$];
  logic [3:0] dq_grant[$];
  logic [1:0] dq_idx[$];
  logic       dq_valid[$];
  logic       dq_terr[$];

  int stim_timeouts = 0;
  bit end_req = 1'b0;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_now(input string name, input logic [3:0] g, input logic [1:0] i,
                            input logic v, input logic t);
    dq_name.push_back(name);
    dq_grant.push_back(g);
    dq_idx.push_back(i);
    dq_valid.push_back(v);
    dq_terr.push_back(t);
  endtask

  task automatic expect_grant(input int i, input int gap, input int len);
    sb_idx.push_back(i);
    sb_gap.push_back(gap);
    sb_len.push_back(len);
  endtask

  task automatic wait_grant();
    int n;
    n = 0;
    while (!bus.grant_valid && n < 20) begin
      step();
      n++;
    end
    if (!bus.grant_valid) stim_timeouts++;
  endtask

  task automatic release_owner(input logic [1:0] i, input bit drop);
    bus.done[i] = 1'b1;
    if (drop) bus.req[i] = 1'b0;
    step();
    bus.done[i] = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [1:0] order [5];

  initial begin
    order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    bus.req  = '0;
    bus.done = '0;
    reset    = 1'b1;
    step();
    step();
    expect_now("reset_state", 4'b0000, 2'd0, 1'b0, 1'b0);

    // single requester from reset, then wrap from rr_ptr=3
    bus.req = 4'b0100;
    expect_grant(2, -1, 2);
    step();
    reset = 1'b0;
    expect_now("idle_latency", 4'b0000, 2'd0, 1'b0, 1'b0);
    step();
    expect_now("single_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
    step();
    release_owner(2'd2, 1'b1);
    expect_now("gap_cycle", 4'b0000, 2'd0, 1'b0, 1'b0);
    bus.req = 4'b1001;
    expect_grant(3, 2, -1);
    expect_grant(0, 2, -1);
    wait_grant();
    step();
    release_owner(2'd3, 1'b1);
    wait_grant();
    step();
    release_owner(2'd0, 1'b1);

    // fairness from a reset with all requests held through it
    reset   = 1'b1;
    bus.req = 4'b1111;
    step();
    step();
    expect_grant(0, -1, 3);
    expect_grant(1, 2, 3);
    expect_grant(2, 2, 3);
    expect_grant(3, 2, 3);
    expect_grant(0, 2, 3);
    expect_grant(1, 2, -1);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wait_grant();
      step();
      step();
      release_owner(order[k], 1'b0);
    end

    // non-owner done ignored
    wait_grant();
    bus.done = 4'b0100;
    step();
    bus.done = 4'b0000;
    expect_now("nonowner_done", 4'b0010, 2'd1, 1'b1, 1'b0);
    step();
    expect_now("nonowner_hold", 4'b0010, 2'd1, 1'b1, 1'b0);

    // withdrawal by owner 2 with cache 0 pending
    bus.done[1] = 1'b1;
    bus.req     = 4'b0101;
    step();
    bus.done    = 4'b0000;
    expect_grant(2, 2, -1);
    expect_grant(0, 2, -1);
    wait_grant();
    step();
    bus.req = 4'b0001;
    step();
    expect_now("withdraw_gap", 4'b0000, 2'd0, 1'b0, 1'b0);
    wait_grant();
    step();
    release_owner(2'd0, 1'b1);

    // reset while BUSY
    bus.req = 4'b0010;
    expect_grant(1, -1, 2);
    wait_grant();
    step();
    reset = 1'b1;
    step();
    expect_now("reset_in_busy", 4'b0000, 2'd0, 1'b0, 1'b0);
    expect_grant(1, -1, -1);
    step();
    reset = 1'b0;
    wait_grant();
    step();
    release_owner(2'd1, 1'b1);

    // ownership bound
    bus.req = 4'b0001;
`ifdef BUS_TIMEOUT_EN
    expect_grant(0, -1, 8);
    wait_grant();
    repeat (8) step();
    expect_now("timeout_gap", 4'b0000, 2'd0, 1'b0, 1'b1);
    bus.req = 4'b0000;
    step();
    expect_now("timeout_pulse_end", 4'b0000, 2'd0, 1'b0, 1'b0);
`else
    expect_grant(0, -1, 70);
    wait_grant();
    repeat (69) step();
    expect_now("long_own", 4'b0001, 2'd0, 1'b1, 1'b0);
    release_owner(2'd0, 1'b1);
    expect_now("long_release", 4'b0000, 2'd0, 1'b0, 1'b0);
`endif

    repeat (3) step();
    end_req = 1'b1;
  end

  // ---------------- monitor ----------------
  initial begin
    bit         prev_valid;
    int         low_cnt;
    int         high_cnt;
    int         cur_len;
    int         terr_cnt;
    int         cycles;
    logic [3:0] one;
    logic [3:0] exp_g;
    int         e_idx, e_gap, e_len;
    string      nm;
    logic [3:0] dg;
    logic [1:0] di;
    logic       dv, dt;

    prev_valid = 1'b0;
    low_cnt    = 0;
    high_cnt   = 0;
    cur_len    = -1;
    terr_cnt   = 0;
    cycles     = 0;
    forever begin
      @(negedge clock);
      cycles++;

      // grant must be the decode of grant_idx; idx must be 0 when invalid
      one   = 4'b0001;
      exp_g = bus.grant_valid ? (one << bus.grant_idx) : 4'b0000;
      checks++;
      if (bus.grant !== exp_g || (!bus.grant_valid && bus.grant_idx !== 2'd0)) begin
        errors++;
        $display("FAIL decode: grant=%b idx=%0d valid=%b, required grant=%b", bus.grant,
                 bus.grant_idx, bus.grant_valid, exp_g);
      end

      if (bus.timeout_err === 1'b1) begin
        terr_cnt++;
        checks++;
        if (!(prev_valid && !bus.grant_valid)) begin
          errors++;
          $display("FAIL terr_timing: timeout_err high with valid=%b prev_valid=%b, required GAP cycle",
                   bus.grant_valid, prev_valid);
        end
      end

      if (bus.grant_valid && !prev_valid) begin
        checks++;
        if (sb_idx.size() == 0) begin
          errors++;
          $display("FAIL unexpected_grant: idx=%0d, required no grant", bus.grant_idx);
          cur_len = -1;
        end else begin
          e_idx = sb_idx.pop_front();
          e_gap = sb_gap.pop_front();
          e_len = sb_len.pop_front();
          cur_len = e_len;
          if (int'(bus.grant_idx) != e_idx) begin
            errors++;
            $display("FAIL grant_order: idx=%0d, required %0d", bus.grant_idx, e_idx);
          end
          if (e_gap >= 0) begin
            checks++;
            if (low_cnt != e_gap) begin
              errors++;
              $display("FAIL turnaround: idle cycles=%0d, required %0d (idx %0d)", low_cnt,
                       e_gap, e_idx);
            end
          end
        end
      end

      if (!bus.grant_valid && prev_valid && cur_len >= 0) begin
        checks++;
        if (high_cnt != cur_len) begin
          errors++;
          $display("FAIL own_length: cycles=%0d, required %0d", high_cnt, cur_len);
        end
      end

      if (bus.grant_valid) begin
        high_cnt = prev_valid ? high_cnt + 1 : 1;
      end else begin
        low_cnt = prev_valid ? 1 : low_cnt + 1;
      end
      prev_valid = bus.grant_valid;

      while (dq_name.size() > 0) begin
        nm = dq_name.pop_front();
        dg = dq_grant.pop_front();
        di = dq_idx.pop_front();
        dv = dq_valid.pop_front();
        dt = dq_terr.pop_front();
        checks++;
        if (bus.grant !== dg || bus.grant_idx !== di || bus.grant_valid !== dv ||
            bus.timeout_err !== dt) begin
          errors++;
          $display("FAIL %s: grant=%b idx=%0d valid=%b terr=%b, required grant=%b idx=%0d valid=%b terr=%b",
                   nm, bus.grant, bus.grant_idx, bus.grant_valid, bus.timeout_err, dg, di, dv, dt);
        end
      end

      if (end_req || cycles > 5000) begin
        if (!end_req) begin
          checks++;
          errors++;
          $display("FAIL watchdog: cycles=%0d, required end before 5000", cycles);
        end
        checks++;
        if (sb_idx.size() != 0) begin
          errors++;
          $display("FAIL missing_grants: pending=%0d, required 0", sb_idx.size());
        end
        checks++;
        if (stim_timeouts != 0) begin
          errors++;
          $display("FAIL grant_wait: expired waits=%0d, required 0", stim_timeouts);
        end
        checks++;
        if (terr_cnt != EXP_TERR) begin
          errors++;
          $display("FAIL terr_count: pulses=%0d, required %0d", terr_cnt, EXP_TERR);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    end
  end

endmodule

// File: doc/bus_grant_scheduler.md
BUS_GRANT_SCHEDULER -- requirements
Module: bus_grant_scheduler

Interface
REQ-001 Parameter: NUM_CACHES, default 4, number of requesting L1 caches (>=2).
REQ-002 Parameter: TIMEOUT_CYCLES, default 64, maximum owned-bus cycles before a forced release (>=2).
REQ-003 Port: clock  input  1  rising-edge clock.
REQ-004 Port: reset  input  1  reset, synchronous, active-high.
REQ-005 Port: req  input  NUM_CACHES  per-cache bus request level, held until granted or withdrawn.
REQ-006 Port: done  input  NUM_CACHES  per-cache end-of-transaction pulse; only the owner's bit is honoured.
REQ-007 Port: grant  output  NUM_CACHES  one-hot grant; all zero when no owner.
REQ-008 Port: grant_idx  output  log2(NUM_CACHES)  binary index of owner; 0 when grant_valid=0.
REQ-009 Port: grant_valid  output  1  high while a cache owns the bus.
REQ-010 Port: timeout_err  output  1  one-cycle pulse on a forced release.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, BUSY, GAP.
REQ-012 IDLE: if |req, select the first requester at or after rr_ptr, searching upward with wrap NUM_CACHES-1 -> 0, and enter BUSY; otherwise remain in IDLE.
REQ-013 grant, grant_idx and grant_valid SHALL be registered and asserted in the cycle after the IDLE cycle that sampled the request (latency 1).
REQ-014 BUSY: the owner SHALL be held stable while req[owner]=1 and done[owner]=0; req and done of non-owners SHALL be ignored.
REQ-015 BUSY -> GAP when done[owner]=1 or req[owner]=0; grant, grant_idx and grant_valid SHALL be deasserted in GAP.
REQ-016 On leaving BUSY, rr_ptr SHALL become owner+1, wrapping NUM_CACHES-1 -> 0.
REQ-017 GAP SHALL last exactly one cycle and then enter IDLE, giving a 2-cycle bus turnaround between owners.
REQ-018 Simultaneous requests SHALL be resolved only by rr_ptr; a requester that stays asserted SHALL be granted within NUM_CACHES ownerships.
REQ-019 grant SHALL always equal the one-hot decode of grant_idx when grant_valid=1.

Reset
REQ-020 Reset SHALL force: state=IDLE, rr_ptr=0, grant=0, grant_idx=0, grant_valid=0, timeout_err=0, timeout counter=0.
REQ-021 Reset asserted mid-BUSY SHALL drop the grant in the next cycle with no GAP and no timeout_err.
REQ-022 Requests held through reset SHALL be arbitrated from rr_ptr=0 starting with the first cycle after reset deasserts.

Configuration
REQ-023 Macro BUS_TIMEOUT_EN defined: a counter SHALL clear on entry to BUSY and increment every BUSY cycle; when it reaches TIMEOUT_CYCLES-1 without done[owner]=1 or req[owner]=0, the FSM SHALL go to GAP, pulse timeout_err for one cycle coincident with GAP, and advance rr_ptr as in REQ-016.
REQ-024 Macro BUS_TIMEOUT_EN undefined: no counter SHALL be instantiated, timeout_err SHALL be tied to 0, and ownership SHALL be unbounded.

Structure
REQ-025 The FSM state encodings (IDLE, BUSY, GAP) and the log2 function SHALL be placed in the shared bus package, alongside the existing bus message codes.
REQ-026 The wrap-around first-requester search SHALL be one combinational sub-module, rr_select (inputs: req vector and rr_ptr; outputs: index and valid); the existing one_hot_encoder SHALL produce grant.

Verification
REQ-027 Single requester: req=4'b0100 from reset -> grant=4'b0100, grant_idx=2 one cycle later; done[2] pulse -> one GAP cycle with grant=0, then rr_ptr=3.
REQ-028 Fairness: req=4'b1111 held with each owner pulsing done after 3 cycles -> grant order 0,1,2,3,0.
REQ-029 Wrap: rr_ptr=3 and req=4'b1001 -> cache 3 granted; after its release -> cache 0 granted.
REQ-030 Non-owner done ignored: owner 1 with done=4'b0100 pulsed -> grant stays 4'b0010.
REQ-031 Withdrawal: owner 2 drops req[2] while req=4'b0001 is pending -> GAP, then grant=4'b0001.
REQ-032 BUS_TIMEOUT_EN with TIMEOUT_CYCLES=8: owner 0 never pulses done -> grant drops after 8 BUSY cycles with one timeout_err pulse; reset in BUSY -> all outputs 0 on the next cycle.
